apb_regbank_slave: RTL and testbench

Parametrised APB slave register bank: the next generation of `apb_slave`, with configurable address/data width, register count, programmable wait states and error responses. It sits on the peripheral side of the APB bus (`apb_if`) and gives the rest of the design a flat view of its registers. `apb_if` tasks `writeData`/`readData` drive it unchanged.

---
 rtl/apbPkg.sv | 27 ++
 rtl/apb_wait_ctr.sv | 23 ++
 rtl/apb_regbank_slave.sv | 132 +++++++++++++
 tb/tb_apb_regbank_slave.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apbPkg.sv
// Shared types, decode constants and the strobe-merge helper for apb_regbank_slave.
package apbPkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Bit positions inside the decode error vector.
  localparam int APB_ERR_MISALIGN = 0;
  localparam int APB_ERR_RANGE    = 1;
  localparam int APB_ERR_W        = 2;

  // Merges new_word into old_word byte by byte; narrower buses pass zero-extended words.
  function automatic logic [31:0] apb_strb_merge(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable 4-bit down-counter that paces the ACCESS phase of apb_regbank_slave.
module apb_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= 4'd0;
    else if (clr)          cnt <= 4'd0;
    else if (load)         cnt <= load_val;
    else if (en && !zero)  cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/apb_regbank_slave.sv
// Parametrised APB register bank with wait states and error responses.
// Define APB_PSTRB_EN to add the pstrb port and byte-granular writes.
module apb_regbank_slave
  import apbPkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_REGS    = 16,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                       pclk,
  input  logic                       rstN,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATA_W/8-1:0]        pstrb,
`endif
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_t          state, next_state;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
`ifdef APB_PSTRB_EN
  logic [DATA_W/8-1:0] strb_q;
`endif
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [ADDR_W-3:0]   idx;
  logic [IDX_W-1:0]    reg_sel;
  logic [APB_ERR_W-1:0] err_vec;
  logic                err, sample, ctr_zero, complete, abort, wr_en;
  logic [DATA_W-1:0]   wr_word;

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge pclk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets its default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (psel && !penable) next_state = SETUP;
      SETUP:  next_state = ACCESS;
      ACCESS: begin
        if (ctr_zero)   next_state = (psel && !penable) ? SETUP : IDLE;
        else if (!psel) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign sample   = (next_state == SETUP);
  assign complete = (state == ACCESS) && ctr_zero;
  assign abort    = (state == ACCESS) && !ctr_zero && !psel;

  // Request fields are frozen at SETUP; later bus changes cannot corrupt the transfer.
  always_ff @(posedge pclk or negedge rstN) begin
    if (!rstN) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
`ifdef APB_PSTRB_EN
      strb_q  <= '0;
`endif
    end else if (sample) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
`ifdef APB_PSTRB_EN
      strb_q  <= pstrb;
`endif
    end
  end

  apb_wait_ctr u_wait_ctr (
    .clk      (pclk),
    .rst_n    (rstN),
    .clr      (abort),
    .load     (sample),
    .load_val (4'(WAIT_CYCLES)),
    .en       (state == ACCESS),
    .zero     (ctr_zero)
  );

  assign idx     = addr_q[ADDR_W-1:2];
  assign reg_sel = idx[IDX_W-1:0];

  always_comb begin
    err_vec                   = '0;
    err_vec[APB_ERR_MISALIGN] = |addr_q[1:0];
    err_vec[APB_ERR_RANGE]    = 32'(idx) >= 32'(NUM_REGS);
  end

  assign err   = |err_vec;
  assign wr_en = complete && write_q && !err;

`ifdef APB_PSTRB_EN
  assign wr_word = DATA_W'(apb_strb_merge(32'(regs[reg_sel]), 32'(wdata_q), 4'(strb_q)));
`else
  assign wr_word = wdata_q;
`endif

  // NOTE: the bank must come out of reset at RESET_VAL, so it is a flop array with async reset, not a RAM.
  always_ff @(posedge pclk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= RESET_VAL;
    end else if (wr_en) begin
      regs[reg_sel] <= wr_word;
    end
  end

  assign pready  = complete;
  assign pslverr = complete && err;
  assign prdata  = (complete && !err && !write_q) ? regs[reg_sel] : '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Self-checking bench for apb_regbank_slave: three instances (WAIT_CYCLES 0, 2, 3) on one shared bus.
module tb_apb_regbank_slave;

  localparam int NI = 3;

  logic                 pclk = 1'b0;
  logic                 rstN;
  logic [7:0]           paddr;
  logic [NI-1:0]        psel;
  logic                 penable, pwrite;
  logic [31:0]          pwdata;
`ifdef APB_PSTRB_EN
  logic [3:0]           pstrb;
  localparam logic [3:0] STRB_FORCE = 4'h0;
`else
  localparam logic [3:0] STRB_FORCE = 4'hF;
`endif
  logic [NI-1:0]        pready_v, pslverr_v;
  logic [NI-1:0][31:0]  prdata_v;
  logic [NI-1:0][511:0] regs_v;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [NI][16];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic        setup_rdy;
    logic        early;
    logic [3:0]  strb;
  } obs_t;

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_regbank_slave #(.WAIT_CYCLES((g == 0) ? 0 : g + 1)) u_dut (
      .pclk    (pclk),
      .rstN    (rstN),
      .paddr   (paddr),
      .psel    (psel[g]),
      .penable (penable),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
`ifdef APB_PSTRB_EN
      .pstrb   (pstrb),
`endif
      .prdata  (prdata_v[g]),
      .pready  (pready_v[g]),
      .pslverr (pslverr_v[g]),
      .regs_o  (regs_v[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : d + 1;
  endfunction

  function automatic bit addr_err(input logic [7:0] a);
    return (a % 4 != 0) || (a / 4 >= 16);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [7:0] a);
    if (addr_err(a)) return 32'h0;
    return mdl[d][a / 4];
  endfunction

  function automatic void model_write(input int d, input logic [7:0] a,
                                      input logic [31:0] data, input logic [3:0] strb);
    if (!addr_err(a)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[d][a / 4][b*8 +: 8] = data[b*8 +: 8];
    end
  endfunction

  function automatic logic [511:0] model_word(input int d);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = mdl[d][i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < NI; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
  endfunction

  // ---------------- bus driver ----------------
  // Drives one transfer on instance d and reports what it saw.
  task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input bit chain_in, input bit chain_out, output obs_t o);
    bit done;
    o.rdata = '0; o.err = 1'b0; o.waits = 0; o.setup_rdy = 1'b0; o.early = 1'b0;
    o.strb = strb | STRB_FORCE;
    if (!chain_in) @(negedge pclk);
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data;
`ifdef APB_PSTRB_EN
    pstrb = strb;
`endif
    @(negedge pclk);
    o.setup_rdy = pready_v[d];
    penable = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge pclk);
      if (pready_v[d] === 1'b1) begin
        done = 1'b1;
        o.rdata = prdata_v[d];
        o.err   = pslverr_v[d];
      end else begin
        o.waits++;
        if (regs_v[d] !== model_word(d)) o.early = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL xfer_timeout inst %0d addr %h: pready got 0 exp 1 within 40 cycles", d, addr);
    end
    if (!chain_out || !done) begin
      @(posedge pclk); #1;
      psel = '0; penable = 1'b0;
      @(negedge pclk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge pclk);
    for (int d = 0; d < NI; d++) begin
      checks++; if (pready_v[d] !== 1'b0) begin errors++; $display("FAIL reset_pready inst %0d got %b exp 0", d, pready_v[d]); end
      checks++; if (pslverr_v[d] !== 1'b0) begin errors++; $display("FAIL reset_pslverr inst %0d got %b exp 0", d, pslverr_v[d]); end
      checks++; if (prdata_v[d] !== 32'h0) begin errors++; $display("FAIL reset_prdata inst %0d got %h exp 0", d, prdata_v[d]); end
      checks++; if (regs_v[d] !== model_word(d)) begin errors++; $display("FAIL reset_regs inst %0d got %h exp %h", d, regs_v[d], model_word(d)); end
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge pclk);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h16;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    checks++; if (pready_v[0] !== 1'b1) begin errors++; $display("FAIL rstmid_in_access got pready %b exp 1", pready_v[0]); end
    rstN = 1'b0;
    #1;
    model_reset();
    checks++; if (pready_v[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pready got %b exp 0", pready_v[0]); end
    checks++; if (pslverr_v[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pslverr got %b exp 0", pslverr_v[0]); end
    checks++; if (prdata_v[0] !== 32'h0) begin errors++; $display("FAIL rstmid_prdata got %h exp 0", prdata_v[0]); end
    psel = '0; penable = 1'b0;
    @(negedge pclk);
    rstN = 1'b1;
    repeat (2) @(negedge pclk);
    checks++; if (regs_v[0][95:64] !== 32'h0) begin errors++; $display("FAIL rstmid_reg2 got %h exp 0", regs_v[0][95:64]); end
  endtask

  task automatic test_write_read();
    obs_t o;
    apb_xfer(0, 1'b1, 8'h08, 32'h16, 4'hF, 1'b0, 1'b0, o);
    model_write(0, 8'h08, 32'h16, o.strb);
    checks++; if (o.setup_rdy !== 1'b0) begin errors++; $display("FAIL wr_setup_pready got %b exp 0", o.setup_rdy); end
    checks++; if (o.waits != 0) begin errors++; $display("FAIL wr_latency got %0d waits exp 0", o.waits); end
    checks++; if (regs_v[0][95:64] !== 32'h16) begin errors++; $display("FAIL wr_regs_o got %h exp 00000016", regs_v[0][95:64]); end
    apb_xfer(0, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 1'b0, o);
    checks++; if (o.rdata !== 32'h16) begin errors++; $display("FAIL rd_prdata got %h exp 00000016", o.rdata); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL rd_pslverr got %b exp 0", o.err); end
  endtask

  task automatic test_wait_states();
    obs_t o;
    apb_xfer(2, 1'b1, 8'h04, 32'h20, 4'hF, 1'b0, 1'b0, o);
    checks++; if (o.waits != 3) begin errors++; $display("FAIL wait3_cycles got %0d exp 3", o.waits); end
    checks++; if (o.early !== 1'b0) begin errors++; $display("FAIL wait3_early_write got %b exp 0", o.early); end
    model_write(2, 8'h04, 32'h20, o.strb);
    checks++; if (regs_v[2][63:32] !== 32'h20) begin errors++; $display("FAIL wait3_reg1 got %h exp 00000020", regs_v[2][63:32]); end
  endtask

  task automatic test_errors();
    obs_t o;
    apb_xfer(0, 1'b0, 8'h41, 32'h0, 4'hF, 1'b0, 1'b0, o);
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL err_misalign_pslverr got %b exp 1", o.err); end
    checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL err_misalign_prdata got %h exp 0", o.rdata); end
    apb_xfer(0, 1'b0, 8'h40, 32'h0, 4'hF, 1'b0, 1'b0, o);
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL err_range_pslverr got %b exp 1", o.err); end
    checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL err_range_prdata got %h exp 0", o.rdata); end
    apb_xfer(0, 1'b1, 8'h40, 32'hFF, 4'hF, 1'b0, 1'b0, o);
    checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL err_wr_pslverr got %b exp 1", o.err); end
    checks++; if (regs_v[0] !== model_word(0)) begin errors++; $display("FAIL err_wr_regs got %h exp %h", regs_v[0], model_word(0)); end
  endtask

  task automatic test_strobe();
    obs_t o;
`ifdef APB_PSTRB_EN
    localparam logic [31:0] EXP = 32'h11BB33DD;
`else
    localparam logic [31:0] EXP = 32'hAABBCCDD;
`endif
    apb_xfer(0, 1'b1, 8'h00, 32'h11223344, 4'hF, 1'b0, 1'b0, o);
    model_write(0, 8'h00, 32'h11223344, o.strb);
    apb_xfer(0, 1'b1, 8'h00, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, o);
    model_write(0, 8'h00, 32'hAABBCCDD, o.strb);
    apb_xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 1'b0, o);
    checks++; if (o.rdata !== EXP) begin errors++; $display("FAIL strobe_read got %h exp %h", o.rdata, EXP); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    apb_xfer(0, 1'b1, 8'h0C, 32'h5, 4'hF, 1'b0, 1'b1, o);
    model_write(0, 8'h0C, 32'h5, o.strb);
    apb_xfer(0, 1'b0, 8'h0C, 32'h0, 4'hF, 1'b1, 1'b0, o);
    checks++; if (o.rdata !== 32'h5) begin errors++; $display("FAIL b2b_read got %h exp 00000005", o.rdata); end
    checks++; if (o.waits != 0) begin errors++; $display("FAIL b2b_latency got %0d waits exp 0", o.waits); end
  endtask

  task automatic test_abort();
    obs_t o;
    apb_xfer(1, 1'b1, 8'h10, 32'hCAFE0001, 4'hF, 1'b0, 1'b0, o);
    model_write(1, 8'h10, 32'hCAFE0001, o.strb);
    @(negedge pclk);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'hDEAD0000;
`ifdef APB_PSTRB_EN
    pstrb = 4'hF;
`endif
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = '0; penable = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      checks++; if (pready_v[1] !== 1'b0) begin errors++; $display("FAIL abort_pready got %b exp 0", pready_v[1]); end
      checks++; if (regs_v[1] !== model_word(1)) begin errors++; $display("FAIL abort_regs got %h exp %h", regs_v[1], model_word(1)); end
    end
    apb_xfer(1, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0, 1'b0, o);
    checks++; if (o.rdata !== 32'hCAFE0001) begin errors++; $display("FAIL abort_readback got %h exp cafe0001", o.rdata); end
    checks++; if (o.waits != 2) begin errors++; $display("FAIL abort_next_latency got %0d waits exp 2", o.waits); end
  endtask

  task automatic test_random();
    obs_t        o;
    int          d, len;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data, exp_rd;
    logic [3:0]  strb;
    bit          exp_err;
    for (int burst = 0; burst < 25; burst++) begin
      d   = $urandom_range(0, NI - 1);
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin
        wr   = 1'($urandom_range(0, 1));
        addr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'(4 * $urandom_range(0, 15));
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        exp_err = addr_err(addr);
        exp_rd  = model_read(d, addr);
        apb_xfer(d, wr, addr, data, strb, k > 0, k < len - 1, o);
        checks++; if (o.err !== exp_err) begin errors++; $display("FAIL rand_pslverr inst %0d addr %h got %b exp %b", d, addr, o.err, exp_err); end
        checks++; if (o.waits != wait_of(d)) begin errors++; $display("FAIL rand_waits inst %0d got %0d exp %0d", d, o.waits, wait_of(d)); end
        checks++; if (o.early !== 1'b0) begin errors++; $display("FAIL rand_early_write inst %0d addr %h got %b exp 0", d, addr, o.early); end
        if (!wr) begin
          checks++; if (o.rdata !== exp_rd) begin errors++; $display("FAIL rand_prdata inst %0d addr %h got %h exp %h", d, addr, o.rdata, exp_rd); end
        end else begin
          model_write(d, addr, data, o.strb);
        end
      end
      checks++; if (regs_v[d] !== model_word(d)) begin errors++; $display("FAIL rand_regs inst %0d got %h exp %h", d, regs_v[d], model_word(d)); end
    end
  endtask

  initial begin
    rstN = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_PSTRB_EN
    pstrb = '0;
`endif
    model_reset();
    repeat (3) @(negedge pclk);
    rstN = 1'b1;
    test_reset();
    test_reset_mid_write();
    test_write_read();
    test_wait_states();
    test_errors();
    test_strobe();
    test_back_to_back();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
